// File: rtl/noc_pkt_rr_mux_pkg.sv
// Shared types and helpers for the packet round-robin NoC merger.
// Header length field defaults and arbiter state encoding live here.
package noc_mux_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    BODY = 1'b1
  } state_e;

  localparam int LEN_LSB_DEF   = 22;
  localparam int LEN_WIDTH_DEF = 8;

  function automatic int next_rr(int ptr, int num_ch);
    return (ptr + 1 >= num_ch) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/noc_pkt_rr_mux_if.sv
// Handshake bundle between the request streams, the merger and the
// memory-bridge side.
interface noc_pkt_rr_mux_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int SRC_WIDTH  = ($clog2(NUM_CH) > 0 ? $clog2(NUM_CH) : 1)
);

  logic [NUM_CH-1:0]            in_val;
  logic [NUM_CH*DATA_WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]            in_rdy;
  logic                         out_val;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [SRC_WIDTH-1:0]         out_src;
  logic                         out_rdy;
  logic                         busy;

  modport slave (
    input  in_val,
    input  in_data,
    output in_rdy,
    output out_val,
    output out_data,
    output out_src,
    input  out_rdy,
    output busy
  );

  modport master (
    output in_val,
    output in_data,
    input  in_rdy,
    input  out_val,
    input  out_data,
    input  out_src,
    output out_rdy,
    input  busy
  );

endinterface

// File: rtl/noc_pkt_rr_mux_skid.sv
// Two-entry valid/ready FIFO that registers the merged output while
// keeping full throughput.
module noc_mux_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_val,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_rdy,
  output logic             pop_val,
  output logic [WIDTH-1:0] pop_data,
  input  logic             pop_rdy,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign push_rdy = (count != 2'd2);
  assign pop_val  = (count != 2'd0);
  assign empty    = (count == 2'd0);
  assign pop_data = mem[rd_ptr];
  assign push     = push_val & push_rdy;
  assign pop      = pop_val & pop_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/noc_pkt_rr_mux.sv
// N-to-1 NoC request merger: packet-granular round-robin arbitration,
// source-tagged flits, registered output through a 2-entry skid.
module noc_pkt_rr_mux
  import noc_mux_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_LSB    = LEN_LSB_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
  parameter int SRC_WIDTH  = ($clog2(NUM_CH) > 0 ? $clog2(NUM_CH) : 1)
) (
  input logic              clk,
  input logic              rst_n,
  noc_pkt_rr_mux_if.slave  bus
);

  localparam int PW = SRC_WIDTH + DATA_WIDTH;

  state_e                state;
  state_e                state_nxt;
  logic [SRC_WIDTH-1:0]  rr_ptr;
  logic [SRC_WIDTH-1:0]  gnt_q;
  logic [SRC_WIDTH-1:0]  grant;
  logic [SRC_WIDTH-1:0]  sel;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [LEN_WIDTH-1:0]  hdr_len;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_CH-1:0]     rdy;
  logic                  any_val;
  logic                  sel_val;
  logic                  sb_rdy;
  logic                  sb_empty;
  logic                  accept;
  logic                  last_flit;
  logic [PW-1:0]         pop_data;

  // Rotating priority scan; descending so the lowest offset wins.
  always_comb begin
    grant   = '0;
    any_val = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin : scan
      int idx;
      idx = (int'(rr_ptr) + k) % NUM_CH;
      if (bus.in_val[idx]) begin
        grant   = SRC_WIDTH'(idx);
        any_val = 1'b1;
      end
    end
  end

  assign sel       = (state == BODY) ? gnt_q : grant;
  assign sel_val   = (state == BODY) ? bus.in_val[gnt_q] : any_val;
  assign sel_data  = bus.in_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign hdr_len   = sel_data[LEN_LSB +: LEN_WIDTH];
  assign accept    = sel_val & sb_rdy & rst_n;
  assign last_flit = (remaining == LEN_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB:  if (accept && hdr_len != '0) state_nxt = BODY;
      BODY: if (accept && last_flit) state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  always_comb begin
    rdy = '0;
    if (rst_n && sb_rdy) begin
      unique case (state)
        ARB:  if (any_val) rdy[grant] = 1'b1;
        BODY: rdy[gnt_q] = 1'b1;
        default: rdy = '0;
      endcase
    end
  end

  assign bus.in_rdy = rdy;
  assign bus.busy   = (state == BODY) | ~sb_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      gnt_q     <= '0;
      remaining <= '0;
    end else if (accept) begin
      if (state == ARB) begin
        if (hdr_len == '0) begin
          rr_ptr <= SRC_WIDTH'(next_rr(int'(grant), NUM_CH));
        end else begin
          remaining <= hdr_len;
          gnt_q     <= grant;
        end
      end else begin
        remaining <= remaining - LEN_WIDTH'(1);
        if (last_flit) begin
          rr_ptr <= SRC_WIDTH'(next_rr(int'(gnt_q), NUM_CH));
        end
      end
    end
  end

  noc_mux_skid #(
    .WIDTH(PW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_val (accept),
    .push_data({sel, sel_data}),
    .push_rdy (sb_rdy),
    .pop_val  (bus.out_val),
    .pop_data (pop_data),
    .pop_rdy  (bus.out_rdy),
    .empty    (sb_empty)
  );

  assign bus.out_src  = pop_data[PW-1 -: SRC_WIDTH];
  assign bus.out_data = pop_data[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_noc_pkt_rr_mux.sv
// Randomised and directed bench for noc_pkt_rr_mux with a queue-based
// reference model of arbitration, framing and output ordering.
module tb_noc_pkt_rr_mux;

  localparam int N   = 4;
  localparam int DW  = 64;
  localparam int SW  = 2;
  localparam int LSB = 22;
  localparam int LW  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  noc_pkt_rr_mux_if #(.NUM_CH(N), .DATA_WIDTH(DW), .SRC_WIDTH(SW)) bus ();

  noc_pkt_rr_mux #(
    .NUM_CH(N), .DATA_WIDTH(DW), .LEN_LSB(LSB),
    .LEN_WIDTH(LW), .SRC_WIDTH(SW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int          cyc;
    int          src;
    logic [DW-1:0] data;
  } rec_t;

  typedef struct {
    int          src;
    logic [DW-1:0] data;
  } ent_t;

  rec_t          acc_log[$];
  rec_t          out_log[$];
  logic [DW-1:0] chq [N][$];
  logic [DW-1:0] pkt_buf[$];
  logic [DW-1:0] exp0[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int seq = 0;
  int vprob = 100;
  int rprob = 100;
  logic [N-1:0] acc_mask = '0;

  int   m_owner = -1;
  int   m_left  = 0;
  int   m_ptr   = 0;
  ent_t m_q[$];

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s cyc=%0d actual=timeout required=done", name, cyc);
  endtask

  function automatic logic [DW-1:0] mk(int ch, int len, int s);
    logic [DW-1:0] d;
    d = {$urandom, $urandom};
    d[63:56] = 8'(ch);
    d[55:40] = 16'(s);
    d[LSB +: LW] = LW'(len);
    return d;
  endfunction

  task automatic add_pkt(int ch, int len);
    logic [DW-1:0] f;
    pkt_buf.delete();
    f = mk(ch, len, seq++);
    pkt_buf.push_back(f);
    chq[ch].push_back(f);
    for (int j = 0; j < len; j++) begin
      f = mk(ch, int'($urandom_range(255)), seq++);
      pkt_buf.push_back(f);
      chq[ch].push_back(f);
    end
  endtask

  // Driver: pops accepted flits, presents queue heads with random gaps.
  initial begin
    bus.in_val  = '0;
    bus.in_data = '0;
    bus.out_rdy = 1'b0;
    forever begin
      logic [N-1:0]    v;
      logic [N*DW-1:0] d;
      @(posedge clk);
      #1;
      v = '0;
      d = '0;
      for (int i = 0; i < N; i++) begin
        if (acc_mask[i] && chq[i].size() > 0) void'(chq[i].pop_front());
        if (chq[i].size() > 0) begin
          d[i*DW +: DW] = chq[i][0];
          v[i] = (int'($urandom_range(99)) < vprob);
        end
      end
      bus.in_val  = v;
      bus.in_data = d;
      bus.out_rdy = (int'($urandom_range(99)) < rprob);
    end
  end

  // Reference model and per-cycle compare.
  always @(negedge clk) begin
    logic [N-1:0]  exp_rdy;
    logic [DW-1:0] d;
    int            a;
    int            len;
    bit            found;
    cyc++;
    if (!rst_n) begin
      check("rst_in_rdy", DW'(bus.in_rdy), '0);
      check("rst_out_val", DW'(bus.out_val), '0);
      check("rst_busy", DW'(bus.busy), '0);
      m_q.delete();
      m_owner = -1;
      m_left = 0;
      m_ptr = 0;
      acc_mask = '0;
    end else begin
      exp_rdy = '0;
      if (m_q.size() < 2) begin
        if (m_owner >= 0) begin
          exp_rdy[m_owner] = 1'b1;
        end else begin
          found = 0;
          for (int k = 0; k < N; k++) begin
            if (!found && bus.in_val[(m_ptr + k) % N]) begin
              exp_rdy[(m_ptr + k) % N] = 1'b1;
              found = 1;
            end
          end
        end
      end
      check("in_rdy", DW'(bus.in_rdy), DW'(exp_rdy));
      check("out_val", DW'(bus.out_val), DW'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        check("out_src", DW'(bus.out_src), DW'(m_q[0].src));
        check("out_data", bus.out_data, m_q[0].data);
      end
      check("busy", DW'(bus.busy), DW'(m_owner >= 0 || m_q.size() > 0));
      acc_mask = bus.in_val & exp_rdy;
      if (m_q.size() > 0 && bus.out_rdy) begin
        out_log.push_back('{cyc, int'(bus.out_src), bus.out_data});
        void'(m_q.pop_front());
      end
      if (acc_mask != '0) begin
        a = 0;
        for (int k = 0; k < N; k++) if (acc_mask[k]) a = k;
        d = bus.in_data[a*DW +: DW];
        acc_log.push_back('{cyc, a, d});
        m_q.push_back('{a, d});
        if (m_owner < 0) begin
          len = int'(d[LSB +: LW]);
          if (len == 0) begin
            m_ptr = (a + 1) % N;
          end else begin
            m_owner = a;
            m_left = len;
          end
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_ptr = (m_owner + 1) % N;
            m_owner = -1;
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_acc(int n, int budget);
    for (int i = 0; i < budget; i++) begin
      if (acc_log.size() >= n) return;
      step();
    end
    timeout("wait_acc");
  endtask

  task automatic wait_out(int n, int budget);
    for (int i = 0; i < budget; i++) begin
      if (out_log.size() >= n) return;
      step();
    end
    timeout("wait_out");
  endtask

  task automatic wait_idle(int budget);
    bit idle;
    for (int i = 0; i < budget; i++) begin
      idle = !bus.busy && !bus.out_val;
      for (int c = 0; c < N; c++) if (chq[c].size() != 0) idle = 0;
      if (idle) return;
      step();
    end
    timeout("wait_idle");
  endtask

  task automatic clear_logs();
    acc_log.delete();
    out_log.delete();
  endtask

  initial begin
    int bad;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // 1: ch2 header len=2 plus two body flits
    clear_logs();
    add_pkt(2, 2);
    exp0 = pkt_buf;
    wait_out(3, 50);
    if (out_log.size() >= 3 && acc_log.size() >= 1) begin
      for (int j = 0; j < 3; j++) begin
        check("t1_src", DW'(out_log[j].src), DW'(2));
        check("t1_data", out_log[j].data, exp0[j]);
        check("t1_cyc", DW'(out_log[j].cyc), DW'(acc_log[0].cyc + 1 + j));
      end
    end
    wait_idle(100);

    // 2: ch0/ch1 len=0 headers alternate one per cycle
    clear_logs();
    for (int r = 0; r < 6; r++) begin
      add_pkt(0, 0);
      add_pkt(1, 0);
    end
    wait_acc(12, 100);
    if (acc_log.size() >= 12) begin
      for (int j = 0; j < 12; j++) begin
        check("t2_src", DW'(acc_log[j].src), DW'(j % 2));
        check("t2_cyc", DW'(acc_log[j].cyc), DW'(acc_log[0].cyc + j));
      end
    end
    wait_idle(100);

    // 3: ch1 header waits for ch0's len=3 packet to finish
    clear_logs();
    add_pkt(0, 3);
    wait_acc(1, 50);
    add_pkt(1, 0);
    wait_acc(5, 50);
    if (acc_log.size() >= 5) begin
      for (int j = 0; j < 4; j++)
        check("t3_acc_src", DW'(acc_log[j].src), DW'(0));
      check("t3_ch1_src", DW'(acc_log[4].src), DW'(1));
      check("t3_ch1_cyc", DW'(acc_log[4].cyc), DW'(acc_log[3].cyc + 1));
    end
    wait_idle(100);
    check("t3_out_cnt", DW'(out_log.size()), DW'(5));
    if (out_log.size() == 5)
      for (int j = 0; j < 5; j++)
        check("t3_out_src", DW'(out_log[j].src), DW'(j == 4 ? 1 : 0));

    // 4: downstream stall mid-packet
    clear_logs();
    add_pkt(0, 7);
    exp0 = pkt_buf;
    wait_acc(2, 50);
    rprob = 0;
    @(posedge clk);
    for (int s = 0; s < 5; s++) begin
      step();
      check("t4_hold", bus.out_data, exp0[out_log.size()]);
    end
    check("t4_in_rdy", DW'(bus.in_rdy), '0);
    check("t4_out_val", DW'(bus.out_val), DW'(1));
    rprob = 100;
    wait_idle(100);
    check("t4_out_cnt", DW'(out_log.size()), DW'(8));
    if (out_log.size() == 8)
      for (int j = 0; j < 8; j++)
        check("t4_order", out_log[j].data, exp0[j]);

    // 5: maximum length packet, then rr_ptr back at 0
    clear_logs();
    add_pkt(3, 255);
    wait_idle(2000);
    check("t5_out_cnt", DW'(out_log.size()), DW'(256));
    bad = 0;
    foreach (out_log[j]) if (out_log[j].src != 3) bad++;
    check("t5_src", DW'(bad), '0);
    clear_logs();
    add_pkt(3, 0);
    add_pkt(2, 0);
    add_pkt(1, 0);
    add_pkt(0, 0);
    wait_acc(4, 50);
    if (acc_log.size() >= 4)
      for (int j = 0; j < 4; j++)
        check("t5_rr", DW'(acc_log[j].src), DW'(j));
    wait_idle(100);

    // 6: reset during BODY with a full skid buffer
    rprob = 0;
    @(posedge clk);
    step();
    clear_logs();
    add_pkt(1, 10);
    wait_acc(2, 50);
    step();
    check("t6_busy", DW'(bus.busy), DW'(1));
    @(posedge clk);
    #1 rst_n = 1'b0;
    for (int c = 0; c < N; c++) chq[c].delete();
    #1;
    check("t6_out_val", DW'(bus.out_val), '0);
    check("t6_in_rdy", DW'(bus.in_rdy), '0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    rprob = 100;
    clear_logs();
    add_pkt(3, 0);
    add_pkt(1, 0);
    wait_acc(2, 50);
    if (acc_log.size() >= 2) begin
      check("t6_first", DW'(acc_log[0].src), DW'(1));
      check("t6_second", DW'(acc_log[1].src), DW'(3));
    end
    wait_idle(100);

    // Random traffic with bubbles and backpressure
    vprob = 70;
    rprob = 60;
    for (int t = 0; t < 1500; t++) begin
      step();
      for (int c = 0; c < N; c++) begin
        if (chq[c].size() < 3 && $urandom_range(99) < 15) begin
          if ($urandom_range(99) < 80) add_pkt(c, int'($urandom_range(3)));
          else add_pkt(c, int'($urandom_range(20)));
        end
      end
    end
    vprob = 100;
    rprob = 100;
    wait_idle(3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/noc_pkt_rr_mux.md
Name: noc_pkt_rr_mux

Overview:
Parametrised N-to-1 NoC request merger placed in front of a memory bridge, so that several NoC2 request streams share one memory port. Arbitration is round-robin at packet granularity: the header length field delimits each packet, and packets are never interleaved. The output passes through a 2-entry skid buffer, so the block sustains full throughput with a registered output. Each output flit is tagged with its source channel index for response steering downstream.

Parameters:
NUM_CH, 4, number of input channels (>=1)
DATA_WIDTH, 64, flit width (`NOC_DATA_WIDTH)
LEN_LSB, 22, LSB of payload-length field in header flit
LEN_WIDTH, 8, width of payload-length field (flits following header)
SRC_WIDTH, ($clog2(NUM_CH)>0 ? $clog2(NUM_CH) : 1), source index width

Ports:
clk  in  1  single clock
rst_n  in  1  reset, asynchronous, active-low
in_val  in  NUM_CH  per-channel flit valid
in_data  in  NUM_CH*DATA_WIDTH  per-channel flit data; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
in_rdy  out  NUM_CH  per-channel ready
out_val  out  1  merged flit valid
out_data  out  DATA_WIDTH  merged flit data
out_src  out  SRC_WIDTH  channel index of out_data
out_rdy  in  1  downstream ready
busy  out  1  high when state==BODY or skid buffer non-empty

Behaviour:
- Reset state: out_val=0, busy=0, state=ARB, rr_ptr=0, remaining=0, skid buffer empty. in_rdy is forced to all-zero while rst_n=0.
- Transfer rule: a flit transfers when in_val[i]&in_rdy[i], or when out_val&out_rdy. Data is held stable until accepted.
- Readiness: at most one in_rdy bit is high per cycle. That bit is high only for the granted channel and only when the skid buffer is not full.
- State ARB:
  - grant = first i with in_val[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_CH. The grant is computed combinationally in the same cycle.
  - Header accepted with len=0: stay in ARB; rr_ptr <= grant+1 mod NUM_CH.
  - Header accepted with len>0: remaining <= len; latch grant into gnt_q; go to BODY.
  - No in_val: stay in ARB; rr_ptr unchanged.
- State BODY:
  - Only gnt_q may be ready; all other channels' in_val are ignored.
  - Each accepted flit decrements remaining.
  - Accepting the flit while remaining==1 returns to ARB with rr_ptr <= gnt_q+1 mod NUM_CH.
  - An in_val drop on gnt_q is a bubble; the grant is held indefinitely (no timeout).
- Width: remaining is LEN_WIDTH bits unsigned. len=2^LEN_WIDTH-1 gives 2^LEN_WIDTH total flits with no wrap.
- Latency: a flit accepted in cycle t is presented on out_val in cycle t+1 when the buffer was empty. Sustained throughput is 1 flit/cycle with out_rdy=1.
- Skid buffer:
  - 2 entries holding {src, data}; FIFO order is preserved.
  - Simultaneous push and pop at count 2 is not possible, because in_rdy=0 when full.
  - Simultaneous push and pop at count 1 leaves the count unchanged.
- NUM_CH=1: rr_ptr is constant 0, out_src=0, packet framing is still tracked.
- Reset mid-packet: all state returns to its reset value immediately (async). Partial packets are discarded; no recovery flit is generated.

Decomposition:
- Package noc_mux_pkg:
  - state enum {ARB, BODY};
  - header length-field constants (LEN_LSB, LEN_WIDTH defaults);
  - function next_rr(ptr, NUM_CH).
- Sub-module noc_mux_skid: a 2-entry valid/ready buffer parametrised by payload width, carrying {src, data}, with asynchronous active-low reset on rst_n. Arbiter FSM, rr_ptr and remaining counter live in the top.

Test Plan:
1. NUM_CH=4, ch2 sends header len=2 then 2 body flits, out_rdy=1 -> out_val high for 3 consecutive cycles starting 1 cycle after header accept; out_src=2 on all three; data in order.
2. ch0 and ch1 continuously present len=0 headers from reset -> accepted source sequence 0,1,0,1,..., one per cycle; ch2/ch3 in_rdy stay 0.
3. ch0 packet len=3 in progress; ch1 header valid from its 2nd flit onward -> in_rdy[1]=0 until ch0's 4th flit accepted; ch1 header accepted next cycle; no interleaving in output.
4. out_rdy=0 for 5 cycles mid-packet -> skid fills to 2, in_rdy all 0, out_data held stable; on out_rdy=1 all flits emerge in order with none lost or duplicated.
5. ch3 header len=255 -> exactly 256 flits with out_src=3, then state ARB and rr_ptr=0.
6. rst_n asserted during BODY with 2 buffered flits -> out_val=0 and in_rdy=0 the same cycle; after release first grant follows rr_ptr=0 priority.
